// File: rtl/inst_cache.sv
// inst_cache: direct-mapped instruction cache with one-word lines.
// A miss fills the line one byte per memory-arbiter acknowledge, then
// the assembled word is presented with a one-cycle ready pulse.
// Build option: define INST_CACHE_EN to include the line array and hit
// path; without it every request is fetched from memory.
module inst_cache #(
    parameter int IDX_W = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _req_in,
    input  logic [31:0] _pc_in,
    output logic [31:0] _inst_out,
    output logic        _inst_ready_out,
    output logic        _mem_req,
    output logic [31:0] _mem_addr,
    input  logic        _mem_ack,
    input  logic [7:0]  _mem_din
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t      state, state_nx;
    logic [1:0]  cnt;        // byte counter within the fill
    logic [29:0] base;       // word address of the line being filled
    logic [23:0] fill_buf;   // bytes 0..2 collected so far
    logic        hit;
    logic [31:0] line_data;
    logic        fill_done;
    logic        unused_pc;

    // Byte lane of the fetch address carries no information for a word fetch.
    assign unused_pc = ^_pc_in[1:0];

    assign fill_done = (state == FILL) && _mem_ack && (cnt == 2'd3);

`ifdef INST_CACHE_EN
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic             line_we;

    assign pc_idx    = _pc_in[IDX_W+1:2];
    assign pc_tag    = _pc_in[31:IDX_W+2];
    assign hit       = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign line_data = data_q[pc_idx];
    assign line_we   = fill_done && !_clear;

    // Valid bits: cleared on reset, set when a fill completes uninterrupted.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (rdy_in && line_we) begin
            valid_q[base[IDX_W-1:0]] <= 1'b1;
        end
    end

    // Tag and data storage, written on a completed fill.
    // NOTE: the payload arrays are not reset; the valid bits alone decide
    // whether a line is usable, which keeps these mappable onto RAM.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && line_we) begin
            tag_q[base[IDX_W-1:0]]  <= base[29:IDX_W];
            data_q[base[IDX_W-1:0]] <= {_mem_din, fill_buf};
        end
    end
`else
    assign hit       = 1'b0;
    assign line_data = '0;
`endif

    // State register; rdy_in low freezes it, reset overrides everything.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else if (rdy_in) begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        state_nx        = state;
        _mem_req        = 1'b0;
        _inst_ready_out = 1'b0;
        _mem_addr       = {base, cnt};
        case (state)
            IDLE: begin
                if (!_clear && _req_in) begin
                    state_nx = hit ? RESP : FILL;
                end
            end
            FILL: begin
                _mem_req = 1'b1;
                if (_clear) begin
                    state_nx = IDLE;
                end else if (fill_done) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                _inst_ready_out = !_clear;
                state_nx        = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: fill address/counter, byte assembly and the output word.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt       <= 2'd0;
            base      <= '0;
            fill_buf  <= '0;
            _inst_out <= '0;
        end else if (rdy_in && !_clear) begin
            case (state)
                IDLE: begin
                    if (_req_in) begin
                        if (hit) begin
                            _inst_out <= line_data;
                        end else begin
                            base <= _pc_in[31:2];
                            cnt  <= 2'd0;
                        end
                    end
                end
                FILL: begin
                    if (_mem_ack) begin
                        cnt <= cnt + 2'd1;
                        case (cnt)
                            2'd0:    fill_buf[7:0]   <= _mem_din;
                            2'd1:    fill_buf[15:8]  <= _mem_din;
                            2'd2:    fill_buf[23:16] <= _mem_din;
                            default: _inst_out       <= {_mem_din, fill_buf};
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: self-checking bench for inst_cache. Expected instruction
// words are queued when a fetch is issued and popped on each ready pulse;
// memory bytes come from a small address-derived model.
module tb_inst_cache;

    localparam int IDX_W = 4;
`ifdef INST_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        _clear;
    logic        _req_in;
    logic [31:0] _pc_in;
    logic [31:0] _inst_out;
    logic        _inst_ready_out;
    logic        _mem_req;
    logic [31:0] _mem_addr;
    logic        _mem_ack;
    logic [7:0]  _mem_din;

    int n_checks = 0;
    int n_bad    = 0;
    logic [31:0] q_inst[$];

    inst_cache #(.IDX_W(IDX_W)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        ._clear         (_clear),
        ._req_in        (_req_in),
        ._pc_in         (_pc_in),
        ._inst_out      (_inst_out),
        ._inst_ready_out(_inst_ready_out),
        ._mem_req       (_mem_req),
        ._mem_addr      (_mem_addr),
        ._mem_ack       (_mem_ack),
        ._mem_din       (_mem_din)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory contents: the word at 0x100 is 0x00000013, elsewhere a hash.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (a[31:2] == 30'h40) return (a[1:0] == 2'd0) ? 8'h13 : 8'h00;
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] b);
        return {mem_byte(b + 32'd3), mem_byte(b + 32'd2), mem_byte(b + 32'd1), mem_byte(b)};
    endfunction

    // One fetch. clr_ack >= 0 aborts with _clear once that many acks are done
    // (clr_with_ack also acks in that cycle); stall_ack >= 0 drops rdy_in for
    // three cycles with _mem_ack pulsed once that many acks are done.
    task automatic fetch(input logic [31:0] pc, input bit hit_exp, input int clr_ack,
                         input bit clr_with_ack, input int stall_ack);
        bit          miss  = !(hit_exp && CACHE_ON);
        bit          abort = (clr_ack >= 0);
        logic [31:0] base  = {pc[31:2], 2'b00};
        logic [31:0] exp_w;
        int acks = 0, cyc = 0, stalls = 0;
        bit done = 0;
        if (!abort) q_inst.push_back(mem_word(base));
        @(negedge clk_in);
        _req_in = 1'b1;
        _pc_in  = pc;
        while (!done) begin
            @(negedge clk_in);
            cyc++;
            _mem_ack = 1'b0;
            if (cyc > 40) begin
                check("timeout", cyc, 0);
                _req_in = 1'b0;
                done = 1;
            end else if (_inst_ready_out) begin
                if (q_inst.size() == 0) begin
                    check("spurious_ready", _inst_ready_out, 0);
                end else begin
                    exp_w = q_inst.pop_front();
                    check("inst", _inst_out, exp_w);
                    check("acks", acks, miss ? 4 : 0);
                    check("latency", cyc, miss ? 5 + stalls : 1);
                end
                _req_in = 1'b0;
                done = 1;
            end else if (_mem_req) begin
                check("mem_addr", _mem_addr, base + acks);
                if (!miss) begin
                    check("hit_mem_req", _mem_req, 0);
                    _req_in = 1'b0;
                    done = 1;
                end else if (acks == stall_ack && stalls < 3) begin
                    rdy_in   = 1'b0;
                    _mem_ack = 1'b1;
                    _mem_din = 8'hEE;
                    stalls++;
                end else begin
                    rdy_in = 1'b1;
                    if (abort && acks == clr_ack) begin
                        _clear   = 1'b1;
                        _req_in  = 1'b0;
                        _mem_ack = clr_with_ack;
                        _mem_din = mem_byte(base + acks);
                        @(negedge clk_in);
                        check("clr_mem_req", _mem_req, 0);
                        check("clr_ready", _inst_ready_out, 0);
                        _clear   = 1'b0;
                        _mem_ack = 1'b0;
                        repeat (3) begin
                            @(negedge clk_in);
                            check("clr_no_ready", _inst_ready_out, 0);
                        end
                        done = 1;
                    end else begin
                        _mem_ack = 1'b1;
                        _mem_din = mem_byte(base + acks);
                        acks++;
                    end
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_inst_out"}, _inst_out, 0);
        check({tag, "_ready"}, _inst_ready_out, 0);
        check({tag, "_mem_req"}, _mem_req, 0);
        check({tag, "_mem_addr"}, _mem_addr, 0);
    endtask

    initial begin
        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        _clear   = 1'b0;
        _req_in  = 1'b0;
        _pc_in   = '0;
        _mem_ack = 1'b0;
        _mem_din = '0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        check_reset_outputs("rst");

        // Cold miss, then repeat (hit only when the array is built in).
        fetch(32'h100, 0, -1, 0, -1);
        fetch(32'h100, 1, -1, 0, -1);

        // Flush after the second ack, then a clean refill.
        fetch(32'h200, 0, 2, 0, -1);
        fetch(32'h200, 0, -1, 0, -1);

        // Direct-mapped eviction on index 0.
        fetch(32'h100, 0, -1, 0, -1);
        fetch(32'h100 + (32'd4 << IDX_W), 0, -1, 0, -1);
        fetch(32'h100, 0, -1, 0, -1);

        // rdy_in stall mid-fill with ack pulsed, then a hit on the result.
        fetch(32'h508, 0, -1, 0, 1);
        fetch(32'h508, 1, -1, 0, -1);

        // Flush on the final ack suppresses the line write.
        fetch(32'h300, 0, 3, 1, -1);
        fetch(32'h300, 0, -1, 0, -1);

        // Top-of-address line; byte-lane bits ignored on the hit.
        fetch(32'hFFFF_FFFC, 0, -1, 0, -1);
        fetch(32'hFFFF_FFFD, 1, -1, 0, -1);

        // _clear beats _req_in in IDLE.
        @(negedge clk_in);
        _clear  = 1'b1;
        _req_in = 1'b1;
        _pc_in  = 32'h700;
        @(negedge clk_in);
        check("idle_clr_mem_req", _mem_req, 0);
        check("idle_clr_ready", _inst_ready_out, 0);
        _clear  = 1'b0;
        _req_in = 1'b0;
        @(negedge clk_in);
        check("idle_clr_after", _mem_req, 0);

        // Reset mid-fill: outputs return to reset values and valid bits clear.
        _req_in = 1'b1;
        _pc_in  = 32'h600;
        @(negedge clk_in);
        check("rf_mem_req", _mem_req, 1);
        _req_in  = 1'b0;
        _mem_ack = 1'b1;
        _mem_din = mem_byte(32'h600);
        @(negedge clk_in);
        _mem_din = mem_byte(32'h601);
        @(negedge clk_in);
        _mem_ack = 1'b0;
        rst_in   = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        check_reset_outputs("rf");
        fetch(32'hFFFF_FFFC, 0, -1, 0, -1);

        check("scoreboard_empty", q_inst.size(), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
